// File: rtl/rr_stream_mux_if.sv
// Stream bundle for rr_stream_mux: N producer channels in, one registered consumer channel out.
// The mux takes the slave side; the producer/consumer environment takes the master side.
interface rr_stream_mux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic            fixed_pri;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output fixed_pri, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  fixed_pri, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel streaming multiplexer: round-robin or fixed-priority grant feeding a single
// registered output stage with valid/ready handshakes on both sides.
module rr_stream_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rr_stream_mux_if.slave  bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant;
  logic [SW-1:0] cand;
  logic          found;
  logic          load;
  logic          take;

  // The output register can accept a word when empty or when its current word leaves now.
  assign load = ~bus.out_valid | bus.out_ready;
  assign take = rst_n & load & found;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = bus.fixed_pri ? SW'(k) : SW'((int'(ptr) + k) % N);
      if (!found && bus.in_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (take) bus.in_ready[grant] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      ptr           <= '0;
    end else if (take) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[int'(grant)*W +: W];
      bus.out_sel   <= grant;
      if (!bus.fixed_pri) ptr <= (grant == SW'(N-1)) ? '0 : grant + 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed, table-driven bench for rr_stream_mux (N=4, W=8) with hand-computed expectations.
module tb_rr_stream_mux;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rr_stream_mux_if #(.N(N), .W(W)) bus ();
  rr_stream_mux #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        fixed;
    logic        ordy;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  sel;
    logic [7:0]  od;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic f, input logic r, input logic [3:0] v, input logic [31:0] d,
                     input logic [3:0] rdy, input logic ov, input logic [1:0] sel, input logic [7:0] od);
    vec_t t;
    t.fixed = f; t.ordy = r; t.valid = v; t.data = d;
    t.rdy = rdy; t.ov = ov; t.sel = sel; t.od = od;
    vecs.push_back(t);
  endtask

  localparam logic [31:0] D0 = 32'h13121110;  // ch i = 0x10+i
  localparam logic [31:0] D1 = 32'h13A51110;  // ch2 = 0xA5
  localparam logic [31:0] D2 = 32'h13123C10;  // ch1 = 0x3C

  initial begin
    // Single channel, then drain; ptr ends at 3
    add(0, 1, 4'b0100, D1, 4'b0100, 1, 2, 8'hA5);
    add(0, 1, 4'b0000, D1, 4'b0000, 0, 2, 8'hA5);
    // Round-robin from ptr=3 with all channels valid
    add(0, 1, 4'b1111, D0, 4'b1000, 1, 3, 8'h13);
    add(0, 1, 4'b1111, D0, 4'b0001, 1, 0, 8'h10);
    add(0, 1, 4'b1111, D0, 4'b0010, 1, 1, 8'h11);
    add(0, 1, 4'b1111, D0, 4'b0100, 1, 2, 8'h12);
    add(0, 1, 4'b1111, D0, 4'b1000, 1, 3, 8'h13);
    // Fixed priority; ptr stays 0
    for (int i = 0; i < 4; i++) add(1, 1, 4'b1111, D0, 4'b0001, 1, 0, 8'h10);
    add(1, 1, 4'b1110, D0, 4'b0010, 1, 1, 8'h11);
    // Back in round-robin from ptr=0: only ch1 valid, ptr -> 2
    add(0, 1, 4'b0010, D2, 4'b0010, 1, 1, 8'h3C);
    // Backpressure for three cycles
    for (int i = 0; i < 3; i++) add(0, 0, 4'b1111, D2, 4'b0000, 1, 1, 8'h3C);
    add(0, 1, 4'b1111, D2, 4'b0100, 1, 2, 8'h12);
    // Wrap-around from ptr=3: ch3, ch0, then ptr=1 grants ch1
    add(0, 1, 4'b1001, D0, 4'b1000, 1, 3, 8'h13);
    add(0, 1, 4'b1001, D0, 4'b0001, 1, 0, 8'h10);
    add(0, 1, 4'b1111, D0, 4'b0010, 1, 1, 8'h11);
    // Drain holds data/sel
    add(0, 1, 4'b0000, D0, 4'b0000, 0, 1, 8'h11);
    // Toggling fixed_pri takes effect this cycle: ptr=2, fixed picks ch1
    add(1, 1, 4'b1110, D0, 4'b0010, 1, 1, 8'h11);

    // Reset state, with inputs active while in reset
    bus.fixed_pri = 1'b0;
    bus.in_data   = D0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'h0);
    check("reset out_valid", 32'(bus.out_valid), 32'h0);
    check("reset out_data", 32'(bus.out_data), 32'h0);
    check("reset out_sel", 32'(bus.out_sel), 32'h0);
    bus.in_valid = 4'b0000;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      bus.fixed_pri = vecs[i].fixed;
      bus.out_ready = vecs[i].ordy;
      bus.in_valid  = vecs[i].valid;
      bus.in_data   = vecs[i].data;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ov));
      check($sformatf("v%0d out_sel", i), 32'(bus.out_sel), 32'(vecs[i].sel));
      check($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].od));
    end

    // Asynchronous reset while a word is held
    bus.fixed_pri = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = D0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("pre-reset out_valid", 32'(bus.out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(bus.out_valid), 32'h0);
    check("async rst out_data", 32'(bus.out_data), 32'h0);
    check("async rst in_ready", 32'(bus.in_ready), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 32'(bus.in_ready), 32'h1);

    // Fairness from reset: 0,1,2,3,0,1,2,3 with no bubbles
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("rr%0d out_valid", i), 32'(bus.out_valid), 32'h1);
      check($sformatf("rr%0d out_sel", i), 32'(bus.out_sel), 32'(i % 4));
      check($sformatf("rr%0d out_data", i), 32'(bus.out_data), 32'(8'h10 + (i % 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised successor to the combinational 2:1/8:1 muxes: N-channel, W-bit streaming multiplexer with per-channel valid/ready handshakes.
- Selects one requesting channel per cycle, by round-robin or fixed priority, and forwards its word through a single registered output stage.
- Used wherever several producers share one consumer, e.g. merging sensor or UART byte streams into one FIFO.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel in bits (1..64).
- SW, $clog2(N) (minimum 1), width of the channel-index field; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- fixed_pri  input  1  0 = round-robin arbitration, 1 = fixed priority (channel 0 highest). Sampled every cycle.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel word-available flag.
- in_ready  output  N  per-channel accept; combinational.
- out_data  output  W  registered selected word.
- out_sel  output  SW  registered index of the channel that supplied out_data.
- out_valid  output  1  registered; out_data/out_sel are valid.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
  - in_ready=0 while rst_n=0.
  - Reset mid-transfer discards the held word. No in_ready is asserted during reset.
- load = ~out_valid | out_ready. The output stage may take a new word this cycle.
- Grant (combinational; at most one bit of in_ready high):
  - fixed_pri=1: lowest index i with in_valid[i]=1.
  - fixed_pri=0: first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap modulo N).
  - in_ready[g] = load & in_valid[g] for the granted g. All other in_ready bits are 0.
  - No valid inputs means no grant and all in_ready=0.
- Transfer on channel g: in_valid[g] & in_ready[g] at a rising edge. Next cycle:
  - out_data = in_data[g]
  - out_sel = g
  - out_valid = 1
- Latency: exactly 1 cycle from input accept to out_valid.
- Sustained throughput is 1 word/cycle while out_ready=1.
- Output drain: out_valid & out_ready with no new transfer sets out_valid=0 next cycle. out_data and out_sel hold their last values.
- Backpressure: out_valid=1 & out_ready=0 holds out_data, out_sel and out_valid stable. All in_ready=0.
- Simultaneous drain and accept in one cycle: the new word replaces the old one with no bubble. out_valid stays 1.
- Pointer update (round-robin only): on a transfer from g, ptr <= (g==N-1) ? 0 : g+1. No transfer leaves ptr unchanged.
- In fixed mode ptr is not updated. Toggling fixed_pri takes effect on the same cycle's grant.
- Fairness: in round-robin mode with all channels continuously valid and out_ready=1, each channel is served exactly once per N consecutive transfers.
- Input contract: a channel holding in_valid=1 keeps in_data stable until accepted. The block does not check this.
- No combinational path from out_ready or in_valid to out_valid, out_data or out_sel.

Test Plan:
1. Reset, then single channel: N=4, W=8, fixed_pri=0, out_ready=1, in_valid=0100, ch2 data=0xA5 for 1 cycle.
   -> Next cycle out_valid=1, out_data=0xA5, out_sel=2.
   -> Cycle after, out_valid=0; ptr=3.
2. Round-robin fairness: all in_valid=1111, ch i data=0x10+i, out_ready=1, 8 cycles from reset.
   -> out_sel sequence 0,1,2,3,0,1,2,3.
   -> out_data sequence 0x10,0x11,0x12,0x13,... with no bubbles.
3. Fixed priority: fixed_pri=1, in_valid=1111 for 4 cycles.
   -> out_sel=0 every cycle; in_ready=0001 each cycle.
   -> Then drop ch0 (in_valid=1110) -> out_sel=1.
4. Backpressure: after a word with out_sel=1 and out_data=0x3C is presented, hold out_ready=0 for 3 cycles with in_valid=1111.
   -> out_data, out_sel and out_valid stable; in_ready=0000.
   -> Raise out_ready -> next word (ch2 in round-robin) appears the following cycle.
5. Wrap-around: ptr=3, in_valid=1001.
   -> ch3 granted first, then ch0.
   -> ptr goes 3 -> 0 -> 1.
6. Reset mid-operation: assert rst_n=0 asynchronously while out_valid=1.
   -> out_valid=0, out_data=0 and in_ready=0000 immediately, without waiting for a clock edge.
   -> After release with in_valid=1111, first out_sel=0.
